// File: rtl/psram_wbuf_pkg.sv
// Shared types for the PSRAM posted write buffer: queue entry, user request,
// drain FSM states and the default queue depth.
package psram_wbuf_pkg;

    localparam int PSRAM_WBUF_DEPTH = 4;

    typedef struct packed {
        logic [22:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } wbuf_entry_t;

    typedef struct packed {
        logic        wen;
        wbuf_entry_t ent;
    } wbuf_req_t;

    typedef enum logic [1:0] { IDLE, WR, RD } wbuf_state_e;

    function automatic logic [63:0] bm_expand(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

endpackage

// File: rtl/psram_wbuf_mem.sv
// Entry storage for the write buffer: valid bits, per-entry address hit vector,
// and a single write port that either loads a fresh entry or byte-merges into one.
module psram_wbuf_mem
    import psram_wbuf_pkg::*;
#(
    parameter int DEPTH = PSRAM_WBUF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we_i,
    input  logic                     merge_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  wbuf_entry_t              wr_entry_i,
    input  logic                     pop_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output wbuf_entry_t              rd_entry_o,
    input  logic [22:0]              cmp_addr_i,
    output logic [DEPTH-1:0]         hit_o
);

    wbuf_entry_t [DEPTH-1:0] ent_q;
    logic        [DEPTH-1:0] vld_q;
    logic        [63:0]      wr_m;

    assign wr_m       = bm_expand(wr_entry_i.mask);
    assign rd_entry_o = ent_q[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            ent_q <= '0;
        end else begin
            if (pop_i) vld_q[rd_idx_i] <= 1'b0;
            if (we_i) begin
                if (merge_i) begin
                    ent_q[wr_idx_i].data <= (ent_q[wr_idx_i].data & ~wr_m) | (wr_entry_i.data & wr_m);
                    ent_q[wr_idx_i].mask <= ent_q[wr_idx_i].mask | wr_entry_i.mask;
                end else begin
                    ent_q[wr_idx_i] <= wr_entry_i;
                    vld_q[wr_idx_i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < DEPTH; i++) hit_o[i] = vld_q[i] && (ent_q[i].addr == cmp_addr_i);
    end

endmodule

// File: rtl/psram_wbuf.sv
// Posted write buffer between the AXI slave user port and psram_core.
// Define PSRAM_WBUF_MERGE_EN to merge same-address writes into the newest queued entry.
module psram_wbuf
    import psram_wbuf_pkg::*;
#(
    parameter int DEPTH = PSRAM_WBUF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     usr_xfer_start_i,
    input  logic                     usr_wen_i,
    input  logic [22:0]              usr_addr_i,
    input  logic [7:0]               usr_bm_i,
    input  logic [63:0]              usr_dat_i,
    output logic [63:0]              usr_dat_o,
    output logic                     usr_wready_o,
    output logic                     usr_rvalid_o,
    output logic                     xfer_valid_o,
    output logic                     xfer_rdwr_o,
    output logic [31:0]              bus_addr_o,
    output logic [63:0]              bus_wr_data_o,
    output logic [7:0]               bus_wr_mask_o,
    input  logic [63:0]              bus_rd_data_i,
    input  logic                     xfer_done_i,
    output logic                     wbuf_empty_o,
    output logic [$clog2(DEPTH):0]   wbuf_cnt_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    wbuf_state_e   state_q, state_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   cnt_q, cnt_d;
    wbuf_req_t     req_q;
    logic          req_vld_q, wready_q, rvalid_q;
    logic [63:0]   dat_q;

    wbuf_entry_t    head_ent, bus_ent;
    logic [DEPTH-1:0] hit;
    logic          merge_ok, commit, push, pop, done_rd;

`ifdef PSRAM_WBUF_MERGE_EN
    logic [AW-1:0] last_idx;
    assign last_idx = tail_q - 1'b1;
    // The in-flight head must not change under the core, so it is excluded.
    assign merge_ok = req_q.wen && hit[last_idx] && !(state_q == WR && last_idx == head_q);
`else
    assign merge_ok = 1'b0;
`endif

    assign commit  = req_vld_q && req_q.wen && (merge_ok || cnt_q != CNT_FULL);
    assign push    = commit && !merge_ok;
    assign pop     = (state_q == WR) && xfer_done_i;
    assign done_rd = (state_q == RD) && xfer_done_i;

    psram_wbuf_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .we_i       (commit),
        .merge_i    (merge_ok),
        .wr_idx_i   (merge_ok ? tail_q - 1'b1 : tail_q),
        .wr_entry_i (req_q.ent),
        .pop_i      (pop),
        .rd_idx_i   (head_q),
        .rd_entry_o (head_ent),
        .cmp_addr_i (req_q.ent.addr),
        .hit_o      (hit)
    );

    always_comb begin
        state_d = state_q;
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        cnt_d   = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        case (state_q)
            IDLE: begin
                // A pending read that hits no queued entry goes ahead of writes.
                if (req_vld_q && !req_q.wen && hit == '0) state_d = RD;
                else if (cnt_q != '0)                      state_d = WR;
            end
            WR:      if (xfer_done_i) state_d = IDLE;
            RD:      if (xfer_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            req_q     <= '0;
            req_vld_q <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            wready_q <= commit;
            rvalid_q <= done_rd;
            if (done_rd) dat_q <= bus_rd_data_i;
            if (commit || done_rd) begin
                req_vld_q <= 1'b0;
            end else if (usr_xfer_start_i && !req_vld_q) begin
                req_vld_q <= 1'b1;
                req_q     <= {usr_wen_i, usr_addr_i, usr_bm_i, usr_dat_i};
            end
        end
    end

    always_comb begin
        bus_ent = '0;
        if (state_q == WR)      bus_ent = head_ent;
        else if (state_q == RD) bus_ent = req_q.ent;
    end

    assign xfer_valid_o  = (state_q != IDLE);
    assign xfer_rdwr_o   = (state_q == RD);
    assign bus_addr_o    = {6'd0, bus_ent.addr, 3'd0};
    assign bus_wr_data_o = bus_ent.data;
    assign bus_wr_mask_o = bus_ent.mask;
    assign usr_dat_o     = dat_q;
    assign usr_wready_o  = wready_q;
    assign usr_rvalid_o  = rvalid_q;
    assign wbuf_empty_o  = (cnt_q == '0);
    assign wbuf_cnt_o    = cnt_q;

    ap_one_outstanding: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        usr_xfer_start_i |-> !req_vld_q);

endmodule
